alu_ctrl: RTL

ALU_CTRL -- requirements
Module: alu_ctrl

---
 rtl/alu_pkg.sv | 30 +++
 rtl/alu_ctrl.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared opcodes, flag indices and FSM state type for alu_ctrl
//
// Purpose: constants and types used by the ALU request/response controller.
//   OP_*           3-bit opcodes; 101..111 are reserved
//   FLAG_*         bit positions inside the 3-bit {overflow, carry, zero} flag vectors
//   state_t        controller FSM states
//   op_is_reserved true for opcodes the ALU datapath must never see
package alu_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_INC = 3'b010;
  localparam logic [2:0] OP_DEC = 3'b011;
  localparam logic [2:0] OP_NEG = 3'b100;

  localparam int FLAG_ZERO     = 0;
  localparam int FLAG_CARRY    = 1;
  localparam int FLAG_OVERFLOW = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  function automatic logic op_is_reserved(input logic [2:0] op);
    return (op > OP_NEG);
  endfunction

endpackage

// File: rtl/alu_ctrl.sv
// rtl/alu_ctrl.sv - request/response sequencer around an external combinational ALU
//
// Purpose: accepts one request at a time, presents it to the ALU for one EXEC
// cycle, captures result and flags, and holds them until the consumer accepts.
// Optional feature: define ALU_CTRL_PERF_CNT_EN to add op_count, a wrapping
// count of completed legal operations.
//
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   req_valid/req_ready            request handshake; req_op, req_a, req_b payload
//   alu_op, alu_a, alu_b           operands to ALU (zero outside a legal EXEC)
//   alu_result, alu_zero,
//   alu_carry, alu_overflow        ALU outputs sampled at the end of EXEC
//   rsp_valid/rsp_ready            response handshake
//   rsp_result, rsp_flags, rsp_err captured response ({overflow, carry, zero})
//   status_clr, status             sticky status of the last legal operation
//   op_count                       (ALU_CTRL_PERF_CNT_EN only) completed legal ops
//   busy                           FSM not in IDLE
module alu_ctrl
  import alu_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_op,
  input  logic [7:0]       req_a,
  input  logic [7:0]       req_b,
  output logic [2:0]       alu_op,
  output logic [7:0]       alu_a,
  output logic [7:0]       alu_b,
  input  logic [7:0]       alu_result,
  input  logic             alu_zero,
  input  logic             alu_carry,
  input  logic             alu_overflow,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [7:0]       rsp_result,
  output logic [2:0]       rsp_flags,
  output logic             rsp_err,
  input  logic             status_clr,
  output logic [2:0]       status,
`ifdef ALU_CTRL_PERF_CNT_EN
  output logic [CNT_W-1:0] op_count,
`endif
  output logic             busy
);

  state_t     state_q, state_d;
  logic [2:0] op_q;
  logic [7:0] a_q, b_q;
  logic       op_rsv;
  logic       req_fire, rsp_fire, capture;
  logic [2:0] alu_flags;

  assign op_rsv = op_is_reserved(op_q);

  always_comb begin
    alu_flags                = '0;
    alu_flags[FLAG_ZERO]     = alu_zero;
    alu_flags[FLAG_CARRY]    = alu_carry;
    alu_flags[FLAG_OVERFLOW] = alu_overflow;
  end

  always_comb begin
    state_d   = state_q;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    busy      = 1'b1;
    capture   = 1'b0;
    alu_op    = '0;
    alu_a     = '0;
    alu_b     = '0;
    case (state_q)
      ST_IDLE: begin
        busy      = 1'b0;
        // Held low while rst is asserted so nothing is accepted in the reset cycle.
        req_ready = !rst;
        if (req_valid && !rst) state_d = ST_EXEC;
      end
      ST_EXEC: begin
        capture = 1'b1;
        // Reserved opcodes never reach the datapath.
        if (!op_rsv && !rst) begin
          alu_op = op_q;
          alu_a  = a_q;
          alu_b  = b_q;
        end
        state_d = ST_RESP;
      end
      ST_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign req_fire = req_valid && req_ready;
  assign rsp_fire = rsp_valid && rsp_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      op_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      rsp_result <= '0;
      rsp_flags  <= '0;
      rsp_err    <= 1'b0;
      status     <= '0;
    end else begin
      state_q <= state_d;
      if (req_fire) begin
        op_q <= req_op;
        a_q  <= req_a;
        b_q  <= req_b;
      end
      if (capture) begin
        rsp_result <= op_rsv ? 8'h00 : alu_result;
        rsp_flags  <= op_rsv ? 3'b000 : alu_flags;
        rsp_err    <= op_rsv;
      end
      // A legal capture overrides a same-cycle clear.
      if (capture && !op_rsv) status <= alu_flags;
      else if (status_clr)    status <= '0;
    end
  end

`ifdef ALU_CTRL_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst)                     op_count <= '0;
    else if (rsp_fire && !rsp_err) op_count <= op_count + 1'b1;
  end
`else
  logic unused_cnt;
  assign unused_cnt = ^{CNT_W, rsp_fire};
`endif

endmodule
